// File: rtl/inter_result_writer.sv
`default_nettype none
// ============================================================================
// inter_result_writer : int8 stream -> zero-extended 32-bit words -> AXI4 INCR
// write bursts. Optional macro INTER_WR_PERF_EN adds perf counters. Rev 1.0
// ============================================================================
module inter_result_writer #(
  parameter int AXI_DW    = 128,
  parameter int AXI_AW    = 64,
  parameter int BURST_LEN = 16,
  parameter int MAX_OUTST = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [AXI_AW-1:0]   addr_G,
  input  logic [31:0]         num_elems,
  output logic                done,
  output logic                error,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [7:0]          s_data,
  output logic [AXI_AW-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [AXI_DW-1:0]   m_axi_wdata,
  output logic [AXI_DW/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready
`ifdef INTER_WR_PERF_EN
  ,
  output logic [31:0]         perf_busy,
  output logic [31:0]         perf_wstall
`endif
);
  localparam int WPB         = AXI_DW / 32;
  localparam int WPB_LG      = $clog2(WPB);
  localparam int BEAT_BYTES  = AXI_DW / 8;
  localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
  localparam int WCW         = $clog2(WPB + 1);
  localparam int OCW         = $clog2(MAX_OUTST + 1);
  localparam logic [WCW-1:0] LAST_WORD  = WCW'(WPB - 1);
  localparam logic [WCW-1:0] FULL_WORDS = WCW'(WPB);
  localparam logic [OCW-1:0] OUTST_MAX  = OCW'(MAX_OUTST);
  localparam logic [8:0]     BURST_MAX  = 9'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AW    = 3'd1,
    S_W     = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t           r_state, w_next;
  logic [31:0]      r_elems_left;
  logic [31:0]      r_beats_left;
  logic [8:0]       r_burst_rem;
  logic [WCW-1:0]   r_word_cnt;
  logic [OCW-1:0]   r_outst;
  logic [8:0]       w_burst_beats;
  logic [32:0]      w_num_round;
  logic             w_start_ok, w_aw_hs, w_w_hs, w_s_hs;

  assign w_start_ok    = (r_state == S_IDLE) && start;
  assign w_aw_hs       = m_axi_awvalid && m_axi_awready;
  assign w_w_hs        = m_axi_wvalid && m_axi_wready;
  assign w_s_hs        = s_valid && s_ready;
  assign w_num_round   = {1'b0, num_elems} + 33'(WPB - 1);
  assign w_burst_beats = (r_beats_left >= 32'(BURST_LEN)) ? BURST_MAX : r_beats_left[8:0];
  assign m_axi_awlen   = 8'(w_burst_beats - 9'd1);
  assign m_axi_awsize  = 3'($clog2(BEAT_BYTES));
  assign m_axi_awburst = 2'b01;
  assign m_axi_bready  = 1'b1;
  assign m_axi_wlast   = m_axi_wvalid && (r_burst_rem == 9'd1);

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    m_axi_awvalid = 1'b0;
    s_ready       = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = (num_elems == 32'd0) ? S_FIN : S_AW;
      S_AW: begin
        m_axi_awvalid = (r_outst != OUTST_MAX);
        if ((r_outst != OUTST_MAX) && m_axi_awready) w_next = S_W;
      end
      S_W: begin
        s_ready = !m_axi_wvalid && (r_word_cnt != FULL_WORDS) && (r_elems_left != 32'd0);
        if (m_axi_wvalid && m_axi_wready && (r_burst_rem == 9'd1))
          w_next = (r_beats_left != 32'd0) ? S_AW : S_DRAIN;
      end
      S_DRAIN: if (r_outst == '0) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_axi_awaddr <= '0;
      r_elems_left <= '0;
      r_beats_left <= '0;
      r_burst_rem  <= '0;
      r_word_cnt   <= '0;
      r_outst      <= '0;
      m_axi_wvalid <= 1'b0;
      m_axi_wdata  <= '0;
      m_axi_wstrb  <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      if (w_start_ok) begin
        m_axi_awaddr <= addr_G;
        r_elems_left <= num_elems;
        r_beats_left <= 32'(w_num_round >> WPB_LG);
        done         <= 1'b0;
        error        <= 1'b0;
      end
      if (w_aw_hs) begin
        m_axi_awaddr <= m_axi_awaddr + AXI_AW'(BURST_BYTES);
        r_beats_left <= r_beats_left - 32'(w_burst_beats);
        r_burst_rem  <= w_burst_beats;
      end
      // A beat goes out when full or when the job's final element lands in it.
      if (w_s_hs) begin
        m_axi_wdata[32*r_word_cnt +: 32] <= {24'd0, s_data};
        m_axi_wstrb[4*r_word_cnt +: 4]   <= 4'hF;
        r_word_cnt   <= r_word_cnt + WCW'(1);
        r_elems_left <= r_elems_left - 32'd1;
        if ((r_word_cnt == LAST_WORD) || (r_elems_left == 32'd1)) m_axi_wvalid <= 1'b1;
      end
      if (w_w_hs) begin
        m_axi_wvalid <= 1'b0;
        m_axi_wdata  <= '0;
        m_axi_wstrb  <= '0;
        r_word_cnt   <= '0;
        r_burst_rem  <= r_burst_rem - 9'd1;
      end
      case ({w_aw_hs, m_axi_bvalid})
        2'b10:   r_outst <= r_outst + OCW'(1);
        2'b01:   if (r_outst != '0) r_outst <= r_outst - OCW'(1);
        default: ;
      endcase
      if (m_axi_bvalid && (m_axi_bresp != 2'b00)) error <= 1'b1;
      if (r_state == S_FIN) done <= 1'b1;
    end
  end

`ifdef INTER_WR_PERF_EN
  always_ff @(posedge clk) begin
    if (!rstn || w_start_ok) begin
      perf_busy   <= '0;
      perf_wstall <= '0;
    end else begin
      if ((r_state != S_IDLE) && (r_state != S_FIN) && (perf_busy != 32'hFFFF_FFFF))
        perf_busy <= perf_busy + 32'd1;
      if (m_axi_wvalid && !m_axi_wready && (perf_wstall != 32'hFFFF_FFFF))
        perf_wstall <= perf_wstall + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire
